// File: rtl/tnn_compress_pkg.sv
// Shared ternary packing types and constants.
// Used by both the compress and decompress paths.
package tnn_compress_pkg;

    localparam int TRITS_PER_BYTE = 5;
    localparam int TRIT_W         = 2;
    localparam logic [7:0] MAX_CODE = 8'd242;

    typedef logic [TRIT_W-1:0] trit_t;

    localparam trit_t TRIT_ZERO = 2'b00;
    localparam trit_t TRIT_POS  = 2'b01;
    localparam trit_t TRIT_NEG  = 2'b11;

    typedef trit_t [TRITS_PER_BYTE-1:0] trit_vec_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } dstate_e;

endpackage

// File: rtl/trit_byte_decoder.sv
// Combinational base-3 decode of one packed byte into 5 trits.
// Out-of-range codes (> MAX_CODE) flag err and force all-zero trits.
module trit_byte_decoder
    import tnn_compress_pkg::*;
(
    input  logic [7:0] i_code,
    output trit_vec_t  o_trits,
    output logic       o_err
);

    always_comb begin
        logic [7:0] v;
        logic [7:0] d;
        v       = i_code;
        d       = '0;
        o_trits = '0;
        o_err   = (i_code > MAX_CODE);
        for (int i = 0; i < TRITS_PER_BYTE; i++) begin
            d = v % 8'd3;
            v = v / 8'd3;
            unique case (d)
                8'd0:    o_trits[i] = TRIT_ZERO;
                8'd1:    o_trits[i] = TRIT_POS;
                default: o_trits[i] = TRIT_NEG;
            endcase
        end
        if (o_err) begin
            o_trits = '0;
        end
    end

endmodule

// File: rtl/ternary_decompress.sv
// Streaming ternary decompressor: one packed byte -> 5 trits per beat.
// ready_o is combinational on ready_i so a new word loads under the last beat.
module ternary_decompress
    import tnn_compress_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [2:0]            len_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [9:0]            trits_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  err_o
);

    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
    localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    logic [BYTES_PER_WORD-1:0][7:0] r_buf;
    logic [IDX_W-1:0]               r_idx;
    logic [2:0]                     r_rem;
    dstate_e                        r_state;

    logic       w_buf_valid;
    logic [2:0] w_len;
    logic [7:0] w_byte;
    trit_vec_t  w_trits;
    logic       w_err;
    logic       w_last;
    logic       w_consume;
    logic       w_free;
    logic       w_accept;

    assign w_buf_valid = (r_state == ST_DRAIN);
    assign w_len       = (len_i > 3'(BYTES_PER_WORD)) ? 3'(BYTES_PER_WORD) : len_i;
    assign w_byte      = r_buf[r_idx];
    assign w_last      = (r_rem == 3'd1);

    trit_byte_decoder u_dec (
        .i_code  (w_byte),
        .o_trits (w_trits),
        .o_err   (w_err)
    );

    assign valid_o = w_buf_valid;
    assign last_o  = w_buf_valid && w_last;
    assign err_o   = w_buf_valid && w_err;
    assign trits_o = w_buf_valid ? w_trits : '0;

    assign w_consume = w_buf_valid && ready_i;
    assign w_free    = w_consume && w_last;
    assign ready_o   = rst_ni && (!w_buf_valid || w_free);
    assign w_accept  = valid_i && ready_o;

    // Empty words (len 0) are accepted but never enter DRAIN.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ST_EMPTY;
            r_buf   <= '0;
            r_idx   <= '0;
            r_rem   <= '0;
        end else begin
            if (w_accept && (w_len != 3'd0)) begin
                r_buf   <= data_i;
                r_idx   <= '0;
                r_rem   <= w_len;
                r_state <= ST_DRAIN;
            end else if (w_free) begin
                r_rem   <= '0;
                r_state <= ST_EMPTY;
            end else if (w_consume) begin
                r_idx <= r_idx + 1'b1;
                r_rem <= r_rem - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ternary_decompress.sv
// Scoreboard bench for ternary_decompress.
// Expected beats are queued on accept and popped as beats are consumed.
module tb_ternary_decompress;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] data_i;
    logic [2:0]  len_i;
    logic        valid_i;
    logic        ready_o;
    logic [9:0]  trits_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic        err_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] q[$];

    ternary_decompress #(.DATA_WIDTH(32)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .data_i  (data_i),
        .len_i   (len_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .trits_o (trits_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .last_o  (last_o),
        .err_o   (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [11:0] exp_beat(input logic [7:0] b, input logic lst);
        logic [9:0] t;
        int v;
        t = '0;
        if (b >= 8'd243) return {1'b1, lst, 10'h000};
        v = int'(b);
        for (int i = 0; i < 5; i++) begin
            case (v % 3)
                0:       t[2*i +: 2] = 2'b00;
                1:       t[2*i +: 2] = 2'b01;
                default: t[2*i +: 2] = 2'b11;
            endcase
            v = v / 3;
        end
        return {1'b0, lst, t};
    endfunction

    task automatic push_word(input logic [31:0] d, input logic [2:0] l);
        int n;
        n = (l > 3'd4) ? 4 : int'(l);
        for (int i = 0; i < n; i++) begin
            q.push_back(exp_beat(d[8*i +: 8], (i == n - 1)));
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d,
                         input logic [2:0] l, input logic r);
        @(negedge clk_i);
        valid_i = v;
        data_i  = d;
        len_i   = l;
        ready_i = r;
        #1;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 32'h0, 3'd4, 1'b1);
            n_cmp++;
            if (ready_o !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_ready_low got %b exp 0", ready_o);
            end
        end
        @(negedge clk_i);
        rst_ni  = 1'b1;
        valid_i = 1'b0;
        #1;
        n_cmp++;
        if ({valid_o, last_o, err_o, trits_o, ready_o} !== {3'b000, 10'h000, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_state got v%b l%b e%b t%h r%b exp v0 l0 e0 t000 r1",
                     valid_o, last_o, err_o, trits_o, ready_o);
        end
    endtask

    task automatic test_single;
        logic [31:0] w;
        logic [11:0] e;
        logic sent;
        int beats, c_acc, c_first, c_last;
        w = 32'hF2790500;
        sent = 0; beats = 0; c_acc = -1; c_first = -1; c_last = -1;
        q.delete();
        for (int c = 0; c < 20 && (!sent || q.size() != 0); c++) begin
            drive(!sent, w, 3'd4, 1'b1);
            if (valid_o && ready_i) begin
                if (c_first < 0) c_first = c;
                c_last = c;
                beats++;
                n_cmp++;
                e = (q.size() != 0) ? q.pop_front() : 12'hFFF;
                if ({err_o, last_o, trits_o} !== e) begin
                    n_bad++;
                    $display("FAIL single_beat%0d got %h exp %h", beats, {err_o, last_o, trits_o}, e);
                end
            end
            if (valid_i && ready_o) begin
                sent = 1; c_acc = c; push_word(w, 3'd4);
            end
        end
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        n_cmp++;
        if (beats !== 4 || q.size() !== 0) begin
            n_bad++;
            $display("FAIL single_count got %0d beats exp 4 (left %0d)", beats, q.size());
        end
        n_cmp++;
        if (c_first !== c_acc + 1 || c_last !== c_first + 3) begin
            n_bad++;
            $display("FAIL single_timing got first %0d last %0d exp %0d %0d",
                     c_first, c_last, c_acc + 1, c_acc + 4);
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] w;
        logic [11:0] e;
        logic sent, r;
        int beats, hold;
        w = 32'hF2790500;
        sent = 0; beats = 0; hold = 0;
        q.delete();
        for (int c = 0; c < 30 && (!sent || q.size() != 0); c++) begin
            r = !(sent && beats == 1 && hold < 3);
            drive(!sent, w, 3'd4, r);
            if (valid_o && !ready_i) begin
                hold++;
                n_cmp++;
                if (trits_o !== 10'h007 || ready_o !== 1'b0 || last_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL bp_hold got t%h r%b l%b exp t007 r0 l0", trits_o, ready_o, last_o);
                end
            end
            if (valid_o && ready_i) begin
                beats++;
                n_cmp++;
                e = (q.size() != 0) ? q.pop_front() : 12'hFFF;
                if ({err_o, last_o, trits_o} !== e || (!e[10] && ready_o !== 1'b0)) begin
                    n_bad++;
                    $display("FAIL bp_beat%0d got %h r%b exp %h", beats, {err_o, last_o, trits_o}, ready_o, e);
                end
            end
            if (valid_i && ready_o) begin
                sent = 1; push_word(w, 3'd4);
            end
        end
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        n_cmp++;
        if (beats !== 4 || hold !== 3 || q.size() !== 0) begin
            n_bad++;
            $display("FAIL bp_count got beats %0d hold %0d exp 4 3", beats, hold);
        end
    endtask

    task automatic test_invalid;
        logic [31:0] w[2];
        logic [11:0] e;
        int n_acc, beats;
        w[0] = 32'h000000F3;
        w[1] = 32'h000000F2;
        n_acc = 0; beats = 0;
        q.delete();
        for (int c = 0; c < 20 && (n_acc < 2 || q.size() != 0); c++) begin
            drive(n_acc < 2, w[n_acc % 2], 3'd1, 1'b1);
            if (valid_o && ready_i) begin
                beats++;
                n_cmp++;
                e = (q.size() != 0) ? q.pop_front() : 12'hFFF;
                if ({err_o, last_o, trits_o} !== e) begin
                    n_bad++;
                    $display("FAIL invalid_beat%0d got %h exp %h", beats, {err_o, last_o, trits_o}, e);
                end
            end
            if (valid_i && ready_o) begin
                push_word(w[n_acc % 2], 3'd1);
                n_acc++;
            end
        end
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        n_cmp++;
        if (beats !== 2 || q.size() !== 0) begin
            n_bad++;
            $display("FAIL invalid_count got %0d exp 2", beats);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w[2];
        logic [11:0] e;
        int n_acc, beats, c_first, c_last;
        logic overlap;
        w[0] = 32'hF2790500;
        w[1] = 32'h0579F2F3;
        n_acc = 0; beats = 0; c_first = -1; c_last = -1; overlap = 0;
        q.delete();
        for (int c = 0; c < 30 && (n_acc < 2 || q.size() != 0); c++) begin
            drive(n_acc < 2, w[n_acc % 2], 3'd4, 1'b1);
            if (valid_o && ready_i) begin
                if (c_first < 0) c_first = c;
                c_last = c;
                beats++;
                n_cmp++;
                e = (q.size() != 0) ? q.pop_front() : 12'hFFF;
                if ({err_o, last_o, trits_o} !== e) begin
                    n_bad++;
                    $display("FAIL b2b_beat%0d got %h exp %h", beats, {err_o, last_o, trits_o}, e);
                end
            end
            if (valid_i && ready_o) begin
                if (n_acc == 1) overlap = valid_o && last_o;
                push_word(w[n_acc % 2], 3'd4);
                n_acc++;
            end
        end
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        n_cmp++;
        if (beats !== 8 || c_last - c_first !== 7 || overlap !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_throughput got beats %0d span %0d overlap %b exp 8 7 1",
                     beats, c_last - c_first, overlap);
        end
    endtask

    task automatic test_partial_empty;
        logic [31:0] w;
        logic [11:0] e;
        logic sent;
        int beats;
        w = 32'hFFFF7905;
        sent = 0; beats = 0;
        q.delete();
        for (int c = 0; c < 20 && (!sent || q.size() != 0); c++) begin
            drive(!sent, w, 3'd2, 1'b1);
            if (valid_o && ready_i) begin
                beats++;
                n_cmp++;
                e = (q.size() != 0) ? q.pop_front() : 12'hFFF;
                if ({err_o, last_o, trits_o} !== e) begin
                    n_bad++;
                    $display("FAIL partial_beat%0d got %h exp %h", beats, {err_o, last_o, trits_o}, e);
                end
            end
            if (valid_i && ready_o) begin
                sent = 1; push_word(w, 3'd2);
            end
        end
        n_cmp++;
        if (beats !== 2) begin
            n_bad++;
            $display("FAIL partial_count got %0d exp 2", beats);
        end
        drive(1'b1, 32'h12345678, 3'd0, 1'b1);
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_accept got r%b v%b exp r1 v0", ready_o, valid_o);
        end
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        n_cmp++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_nobeat got r%b v%b exp r1 v0", ready_o, valid_o);
        end
    endtask

    task automatic test_reset_midword;
        logic [31:0] w;
        logic [11:0] e;
        logic sent;
        int beats;
        w = 32'hF2790500;
        sent = 0; beats = 0;
        q.delete();
        for (int c = 0; c < 20 && beats < 1; c++) begin
            drive(!sent, w, 3'd4, 1'b1);
            if (valid_o && ready_i) begin
                beats++;
                n_cmp++;
                e = (q.size() != 0) ? q.pop_front() : 12'hFFF;
                if ({err_o, last_o, trits_o} !== e) begin
                    n_bad++;
                    $display("FAIL rstmid_beat1 got %h exp %h", {err_o, last_o, trits_o}, e);
                end
            end
            if (valid_i && ready_o) begin
                sent = 1; push_word(w, 3'd4);
            end
        end
        @(negedge clk_i);
        rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        #1;
        n_cmp++;
        if (ready_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_ready_low got %b exp 0", ready_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_cmp++;
        if (valid_o !== 1'b0 || ready_o !== 1'b1 || trits_o !== 10'h000) begin
            n_bad++;
            $display("FAIL rstmid_flush got v%b r%b t%h exp v0 r1 t000", valid_o, ready_o, trits_o);
        end
        q.delete();
        sent = 0; beats = 0; w = 32'h00000079;
        for (int c = 0; c < 20 && (!sent || q.size() != 0); c++) begin
            drive(!sent, w, 3'd1, 1'b1);
            if (valid_o && ready_i) begin
                beats++;
                n_cmp++;
                e = (q.size() != 0) ? q.pop_front() : 12'hFFF;
                if ({err_o, last_o, trits_o} !== e) begin
                    n_bad++;
                    $display("FAIL rstmid_new got %h exp %h", {err_o, last_o, trits_o}, e);
                end
            end
            if (valid_i && ready_o) begin
                sent = 1; push_word(w, 3'd1);
            end
        end
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        n_cmp++;
        if (beats !== 1 || valid_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_count got %0d v%b exp 1 v0", beats, valid_o);
        end
    endtask

    task automatic test_random;
        logic [31:0] w;
        logic [2:0] l;
        logic [11:0] e;
        int n_acc;
        n_acc = 0;
        q.delete();
        w = $urandom; l = 3'($urandom_range(0, 7));
        for (int c = 0; c < 400 && (n_acc < 12 || q.size() != 0); c++) begin
            drive(n_acc < 12, w, l, ($urandom_range(0, 3) != 0));
            if (valid_o && ready_i) begin
                n_cmp++;
                e = (q.size() != 0) ? q.pop_front() : 12'hFFF;
                if ({err_o, last_o, trits_o} !== e) begin
                    n_bad++;
                    $display("FAIL random_beat got %h exp %h", {err_o, last_o, trits_o}, e);
                end
            end
            if (valid_i && ready_o) begin
                push_word(w, l);
                n_acc++;
                w = $urandom;
                if (n_acc % 3 == 0) w[15:8] = 8'hF0 + 8'($urandom_range(0, 15));
                l = 3'($urandom_range(0, 7));
            end
        end
        drive(1'b0, 32'h0, 3'd0, 1'b1);
        n_cmp++;
        if (n_acc !== 12 || q.size() !== 0) begin
            n_bad++;
            $display("FAIL random_drain got acc %0d left %0d exp 12 0", n_acc, q.size());
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = '0;
        len_i   = '0;
        test_reset();
        test_single();
        test_backpressure();
        test_invalid();
        test_back_to_back();
        test_partial_empty();
        test_reset_midword();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ternary_decompress.md
Name: ternary_decompress

Overview:
Streaming decompressor for packed ternary activations, the inverse of the threshold/compress path. Accepts 32-bit words holding up to four compressed bytes; each byte encodes 5 trits in base 3. Emits one byte's worth of decoded trits (5 x 2-bit) per output beat under valid/ready backpressure. Sits between the activation memory read port and the ternary datapath that consumes unpacked trits.

Parameters:
DATA_WIDTH, 32, input word width; must be a multiple of 8
BYTES_PER_WORD, DATA_WIDTH/8 (4), compressed bytes per input word; derived, not overridden
TRITS_PER_BYTE, 5, trits per compressed byte; fixed by the encoding

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, synchronous, active-low
data_i  in  DATA_WIDTH  compressed word; byte 0 = bits [7:0], decoded first
len_i  in  3  number of valid bytes in data_i, 1..4; 0 = empty word
valid_i  in  1  input word valid
ready_o  out  1  input word accepted when valid_i && ready_o at posedge
trits_o  out  10  decoded trits; trit i at bits [2i+1:2i]
valid_o  out  1  output beat valid
ready_i  in  1  downstream ready; beat consumed when valid_o && ready_i
last_o  out  1  beat is the last valid byte of its word
err_o  out  1  beat's source byte was out of range (>=243)

Behaviour:
- Encoding: byte = sum d_i*3^i, i=0..4, d_i in {0,1,2}. Trit mapping: d=0 -> 2'b00 (0), d=1 -> 2'b01 (+1), d=2 -> 2'b11 (-1). 2'b10 is never emitted.
- Byte values 243..255: trits_o = 0, err_o = 1 for that beat. Otherwise err_o = 0.
- State: word buffer reg (DATA_WIDTH), byte index reg (2b), remaining-count reg (3b), buf_valid flag.
- States: EMPTY (buf_valid=0) and DRAIN (buf_valid=1).
- EMPTY: ready_o = 1. On accept with len_i in 1..4: load buffer, idx=0, rem=len_i, go to DRAIN. On accept with len_i = 0: word is dropped and no beat is produced. len_i > 4 is treated as 4.
- DRAIN: valid_o = 1. trits_o/err_o are decoded combinationally from buffer byte[idx]. last_o = (rem == 1). On consume with rem > 1: idx++, rem--. On consume with rem == 1: buffer frees.
- Back-to-back: ready_o = !buf_valid || (valid_o && ready_i && last_o). An accept in the same cycle as the last consume loads the new word. No bubble, so throughput is 1 beat/cycle sustained.
- Latency: a word accepted at edge k presents its first beat in the cycle after edge k.
- Backpressure: while valid_o && !ready_i, trits_o, last_o, err_o and internal state hold stable.
- Reset (rst_ni = 0 at posedge, including mid-word): buf_valid=0, idx=0, rem=0, and pending beats are discarded.
- Reset values: valid_o=0, last_o=0, err_o=0, trits_o=0 (gated by buf_valid), ready_o=1 after the reset edge. While rst_ni is low, ready_o=0.
- No combinational path from valid_i to valid_o. ready_o depends combinationally on ready_i (documented).

Decomposition:
- Package tnn_compress_pkg holds:
  - TRITS_PER_BYTE=5, TRIT_W=2, MAX_CODE=242
  - typedef trit_t (logic [1:0])
  - constants TRIT_ZERO/TRIT_POS/TRIT_NEG
  - typedef trit_vec_t (trit_t [4:0])
  - these are shared with threshold_compress.
- Sub-module trit_byte_decoder: combinational, 8-bit in -> trit_vec_t + err. Implement as a divide-by-3 chain or a 256-entry case.
- Top module: buffer, counters, handshake.

Test Plan:
- Single word data_i=0xF2790500, len_i=4, ready_i=1: four consecutive beats trits_o=0x000, 0x007, 0x155, 0x3FF. last_o=1 only on the 4th beat; err_o=0 throughout.
- Backpressure: same word, ready_i low for 3 cycles at beat 2. trits_o holds 0x007 stably; the sequence completes unchanged and ready_o stays 0 until the last beat.
- Invalid code: data_i=0x000000F3, len_i=1 -> one beat, trits_o=0x000, err_o=1, last_o=1. Then 0x000000F2 -> 0x3FF, err_o=0.
- Throughput: two words (len 4 each) offered with valid_i held and ready_i=1. Eight beats in 8 consecutive cycles; second word is accepted in the same cycle as the first word's last beat.
- Partial/empty: len_i=2 on 0xFFFF7905 -> beats 0x007, 0x155 (last). The upper bytes are ignored. len_i=0 -> accepted, no beat produced, ready_o stays 1.
- Reset mid-word: rst_ni low for 1 cycle after beat 1 of a len-4 word. Next cycle valid_o=0, then ready_o=1; a new word 0x00000079, len 1, yields a single beat 0x155.
